// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared constants, state encoding and helpers for the grant arbiters
package arb_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Index of the set bit of a one-hot vector (zero for an all-zero vector).
    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (oh[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick: first set request at or above ptr, with wrap
module rr_pick
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] pick,
    output logic             any
);

    logic [2*N_REQ-1:0] rot_dbl;
    logic [N_REQ-1:0]   rot;
    logic [N_REQ-1:0]   rot_pick;
    logic [2*N_REQ-1:0] back_dbl;

    // Rotate so ptr lands at bit 0, isolate the lowest set bit, rotate back.
    always_comb begin
        rot_dbl  = {req, req} >> ptr;
        rot      = rot_dbl[N_REQ-1:0];
        rot_pick = rot & (~rot + N_REQ'(1));
        back_dbl = {rot_pick, rot_pick} << ptr;
        pick     = back_dbl[2*N_REQ-1:N_REQ];
        any      = |req;
    end

endmodule

// File: rtl/rr_grant_arbiter.sv
// rtl/rr_grant_arbiter.sv - registered round-robin arbiter with hold limit and one-hot grant
module rr_grant_arbiter #(
    parameter int N_REQ    = 8,
    parameter int HOLD_MAX = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic             gnt_valid,
    output logic             timeout
);
    import arb_pkg::*;

    localparam logic [7:0] HCNT_LAST = 8'(HOLD_MAX - 1);

    state_t           state, state_n;
    logic [IDX_W-1:0] ptr, ptr_n;
    logic [IDX_W-1:0] own, own_n;
    logic [7:0]       hcnt, hcnt_n;
    logic [N_REQ-1:0] gnt_n;
    logic             gnt_valid_n;
    logic             timeout_n;

    logic [N_REQ-1:0] pick;
    logic             pick_any;
    logic             rel_done, rel_drop, rel_lim;

    rr_pick u_pick (
        .req  (req),
        .ptr  (ptr),
        .pick (pick),
        .any  (pick_any)
    );

    // State, pointer, hold counter and output registers; reset clears grant asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            own       <= '0;
            hcnt      <= '0;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            own       <= own_n;
            hcnt      <= hcnt_n;
            gnt       <= gnt_n;
            gnt_valid <= gnt_valid_n;
            timeout   <= timeout_n;
        end
    end

    // Next-state: grant the rotated pick in IDLE, release on done/drop/limit in GRANT.
    always_comb begin
        state_n     = state;
        ptr_n       = ptr;
        own_n       = own;
        hcnt_n      = hcnt;
        gnt_n       = gnt;
        gnt_valid_n = gnt_valid;
        timeout_n   = 1'b0;
        rel_done    = done;
        rel_drop    = ~req[own];
        rel_lim     = (hcnt == HCNT_LAST);
        case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    gnt_n       = pick;
                    gnt_valid_n = 1'b1;
                    hcnt_n      = '0;
                    own_n       = onehot_to_idx(pick);
                    state_n     = ST_GRANT;
                end else begin
                    gnt_n       = '0;
                    gnt_valid_n = 1'b0;
                end
            end
            ST_GRANT: begin
                if (rel_done || rel_drop || rel_lim) begin
                    gnt_n       = '0;
                    gnt_valid_n = 1'b0;
                    ptr_n       = own + IDX_W'(1);
                    state_n     = ST_IDLE;
                    // Only a pure hold-limit release is reported as a timeout.
                    timeout_n   = rel_lim && !rel_done && !rel_drop;
                end else begin
                    hcnt_n      = hcnt + 8'd1;
                end
            end
            default: begin
                state_n     = ST_IDLE;
                gnt_n       = '0;
                gnt_valid_n = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// tb/tb_rr_grant_arbiter.sv - directed self-checking bench for rr_grant_arbiter
module tb_rr_grant_arbiter;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic       gnt_valid;
    logic       timeout;

    int checks;
    int errors;

    rr_grant_arbiter #(.N_REQ(8), .HOLD_MAX(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance one clock; inputs change and outputs are sampled on the falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = 8'hFF; done = 1'b0;
        step(); step();
        checks++; if (gnt !== 8'h00) begin errors++; $display("FAIL reset_gnt: got %h expected 00", gnt); end
        checks++; if (gnt_valid !== 1'b0) begin errors++; $display("FAIL reset_gnt_valid: got %b expected 0", gnt_valid); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", timeout); end
        rst_n = 1'b1;
        step();
        checks++; if (gnt !== 8'h01) begin errors++; $display("FAIL reset_first_gnt: got %h expected 01", gnt); end
        checks++; if (gnt_valid !== 1'b1) begin errors++; $display("FAIL reset_first_valid: got %b expected 1", gnt_valid); end
    endtask

    // entered holding gnt=01 with req=FF; ends idle with ptr=1
    task automatic test_rotation();
        logic [7:0] exp;
        for (int i = 0; i <= 8; i++) begin
            exp = (i == 8) ? 8'h01 : (8'h01 << i);
            checks++; if (gnt !== exp) begin errors++; $display("FAIL rotation_gnt[%0d]: got %h expected %h", i, gnt, exp); end
            done = 1'b1;
            step();
            done = 1'b0;
            checks++; if (gnt !== 8'h00 || timeout !== 1'b0) begin errors++; $display("FAIL rotation_gap[%0d]: got gnt %h timeout %b expected 00 0", i, gnt, timeout); end
            if (i == 8) req = 8'h00;
            step();
        end
    endtask

    // ptr=1 on entry; ends idle with ptr=3
    task automatic test_skip_wrap();
        req = 8'h20; step();
        checks++; if (gnt !== 8'h20) begin errors++; $display("FAIL skip_setup: got %h expected 20", gnt); end
        done = 1'b1; step(); done = 1'b0;
        req = 8'h05; step();
        checks++; if (gnt !== 8'h01) begin errors++; $display("FAIL skip_wrap_first: got %h expected 01", gnt); end
        done = 1'b1; step(); done = 1'b0;
        step();
        checks++; if (gnt !== 8'h04) begin errors++; $display("FAIL skip_wrap_second: got %h expected 04", gnt); end
        done = 1'b1; step(); done = 1'b0;
        req = 8'h00; step();
        done = 1'b1; step(); done = 1'b0;
        checks++; if (gnt !== 8'h00) begin errors++; $display("FAIL idle_done_ignored: got %h expected 00", gnt); end
    endtask

    // HOLD_MAX=4; ptr=3 on entry; ends holding a fresh 08 grant (hcnt=0)
    task automatic test_timeout();
        req = 8'h08; step();
        for (int c = 0; c < 4; c++) begin
            checks++; if (gnt !== 8'h08 || timeout !== 1'b0) begin errors++; $display("FAIL timeout_hold[%0d]: got gnt %h timeout %b expected 08 0", c, gnt, timeout); end
            step();
        end
        checks++; if (gnt !== 8'h00 || timeout !== 1'b1) begin errors++; $display("FAIL timeout_release: got gnt %h timeout %b expected 00 1", gnt, timeout); end
        step();
        checks++; if (gnt !== 8'h08 || timeout !== 1'b0) begin errors++; $display("FAIL timeout_regrant: got gnt %h timeout %b expected 08 0", gnt, timeout); end
    endtask

    // done on the 4th grant cycle coincides with the limit: no timeout, ptr advances to 4
    task automatic test_coincident();
        step(); step(); step();
        checks++; if (gnt !== 8'h08) begin errors++; $display("FAIL coinc_fourth_cycle: got %h expected 08", gnt); end
        done = 1'b1; step(); done = 1'b0;
        checks++; if (gnt !== 8'h00 || timeout !== 1'b0) begin errors++; $display("FAIL coinc_release: got gnt %h timeout %b expected 00 0", gnt, timeout); end
        req = 8'hFF; step();
        checks++; if (gnt !== 8'h10) begin errors++; $display("FAIL coinc_ptr_advance: got %h expected 10", gnt); end
        done = 1'b1; step(); done = 1'b0;
        req = 8'h00; step();
    endtask

    // ptr=5 on entry
    task automatic test_req_drop();
        req = 8'h08; step();
        checks++; if (gnt !== 8'h08) begin errors++; $display("FAIL drop_setup: got %h expected 08", gnt); end
        req = 8'h38; step();
        checks++; if (gnt !== 8'h08) begin errors++; $display("FAIL drop_no_preempt: got %h expected 08", gnt); end
        req = 8'h30; step();
        checks++; if (gnt !== 8'h00 || timeout !== 1'b0) begin errors++; $display("FAIL drop_release: got gnt %h timeout %b expected 00 0", gnt, timeout); end
        step();
        checks++; if (gnt !== 8'h10) begin errors++; $display("FAIL drop_next_owner: got %h expected 10", gnt); end
    endtask

    // reset while 10 is granted: clears at once, then ptr=0 gives 01 from req=FF
    task automatic test_async_reset();
        req = 8'hFF;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (gnt !== 8'h00 || gnt_valid !== 1'b0) begin errors++; $display("FAIL async_reset_clear: got gnt %h valid %b expected 00 0", gnt, gnt_valid); end
        @(negedge clk); rst_n = 1'b1;
        step();
        checks++; if (gnt !== 8'h01) begin errors++; $display("FAIL async_reset_ptr: got %h expected 01", gnt); end
    endtask

    task automatic test_random_invariant();
        for (int n = 0; n < 10000; n++) begin
            req  = 8'($urandom);
            done = ($urandom_range(0, 3) == 0);
            step();
            checks++; if (!$onehot0(gnt) || gnt_valid !== (gnt != 8'h00)) begin errors++; $display("FAIL invariant[%0d]: got gnt %h valid %b expected onehot0 and matching valid", n, gnt, gnt_valid); end
        end
        req = 8'h00; done = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_rotation();
        test_skip_wrap();
        test_timeout();
        test_coincident();
        test_req_drop();
        test_async_reset();
        test_random_invariant();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_grant_arbiter.md
# rr_grant_arbiter

Registered round-robin arbiter for eight requesters that produces a strictly one-hot (or all-zero) grant vector. It sits directly upstream of the 8-to-3 one-hot encoder. Its `gnt` output drives the encoder input, so the encoder only ever sees a legal one-hot code or zero. Grants are held until the owner finishes, drops its request, or exceeds a hold limit, and priority then rotates past the last owner.

## Interface
- `N_REQ`, 8, number of requesters; fixed at 8 to match the encoder width.
- `HOLD_MAX`, 15, maximum cycles a grant is held before forced release; legal range 1..255.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `req` input 8: request vector; bit i is requester i. Any number of bits may be set.
- `done` input 1: current owner finished; valid only while `gnt_valid`=1.
- `gnt` output 8: registered grant; one-hot while granted, 8'h00 otherwise.
- `gnt_valid` output 1: 1 exactly when `gnt`≠0.
- `timeout` output 1: one-cycle pulse when a grant is force-released by the hold limit.

## Operation
- States are IDLE and GRANT.
- Reset, async assert: `gnt`=8'h00, `gnt_valid`=0, `timeout`=0. The priority pointer `ptr` is 3'd0, hold counter `hcnt`=0, state is IDLE.
- **IDLE:**
  - If `req`≠0, pick the first set bit scanning upward from `ptr` with wrap (ptr, ptr+1, …, 7, 0, …, ptr−1).
  - Register that one-hot as `gnt`, set `gnt_valid`=1, set `hcnt`=0, and go to GRANT.
  - If `req`=0, stay in IDLE with outputs zero.
- **GRANT, owner index k:** release when any of the following holds in a cycle.
  - `done`=1.
  - `req[k]`=0.
  - `hcnt`=HOLD_MAX−1 (timeout).
- **On release:**
  - Next cycle `gnt`=8'h00, `gnt_valid`=0, state IDLE.
  - `ptr` becomes (k+1) mod 8, wrapping 7→0.
  - `timeout` pulses 1 for that one cycle only if the release was caused solely by the hold limit. If `done` or a `req[k]` drop coincides with the limit, `timeout`=0.
- If no release condition holds, `hcnt` increments. `hcnt` is 8 bits and never exceeds HOLD_MAX−1.
- Requests from non-owners are ignored during GRANT. No preemption.
- `done` asserted in IDLE is ignored.
- `gnt` is never multi-hot in any cycle, including immediately after reset deassertion.

## Timing
- Request-to-grant latency: 1 cycle. `req` is sampled on edge t in IDLE and `gnt` is valid after edge t.
- Release-to-zero: 1 cycle. A mandatory idle cycle with `gnt`=0 separates consecutive grants. The downstream encoder holds its previous output during that cycle, which the team accepts.
- With HOLD_MAX=H and the owner holding continuously, `gnt` is high for exactly H cycles, then one zero cycle.
- Maximum wait for a continuously requesting bit: 7·(H+1) cycles.
- Reset mid-grant: `gnt` clears immediately (asynchronously), and `ptr` returns to 0.
- All outputs are registered. There is no combinational path from `req` or `done` to any output.

## Structure
- Shared package/header `arb_pkg`:
  - Constants `N_REQ`=8 and `IDX_W`=3.
  - State encoding `ST_IDLE`=1'b0, `ST_GRANT`=1'b1.
- Sub-module `rr_pick`: combinational; inputs `req[7:0]`, `ptr[2:0]`; outputs one-hot `pick[7:0]` and `any`.
  - Implement as a rotate–priority–rotate-back circuit.
  - It is reused by later arbiters in the codebase.
- Top-level block holds the FSM, `ptr`, `hcnt`, and output registers.

## Test plan
- **Reset:** assert `rst_n`=0 with `req`=8'hFF → `gnt`=8'h00, `gnt_valid`=0, `timeout`=0. Release reset → the next edge gives `gnt`=8'h01.
- **Rotation:** `req`=8'hFF held, `done` pulsed 1 on every grant cycle → `gnt` sequence 01, 00, 02, 00, 04, …, 80, 00, 01 (wrap).
- **Skip and wrap:** `ptr`=6 (after a grant to bit 5), `req`=8'h05 → `gnt`=8'h01. Next grant with `req`=8'h05 → `gnt`=8'h04.
- **Timeout:** HOLD_MAX=4, `req`=8'h08 held, `done`=0 → `gnt`=8'h08 for exactly 4 cycles. `timeout`=1 in the following zero cycle, then `gnt`=8'h08 regrants.
- **Coincident release:** HOLD_MAX=4, `done`=1 on the 4th grant cycle → `timeout` stays 0 and `ptr` advances.
- **Request drop and invariant:** owner 3 drops `req[3]` mid-grant while `req`=8'h30 → `gnt`=00 next cycle, then 8'h10. Over 10k random cycles, `gnt` is checked every cycle to be one-hot or zero.
